// File: rtl/ps2_frame_rx_pkg.sv
// Shared PS/2 device-to-host frame constants and receive FSM encoding.
package ps2_frame_rx_pkg;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam logic [7:0]  BREAK_CODE      = 8'hF0;
  localparam logic [7:0]  EXT_CODE        = 8'hE0;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  // True when the eight data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser for one asynchronous PS/2 line, optionally followed by a glitch filter.
module ps2_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic line_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  generate
    if (FILTER_LEN == 0) begin : g_bypass
      assign line_o = synced;
    end else begin : g_filter
      localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

      logic [CntW-1:0] cnt_q, cnt_d;
      logic            filt_q, filt_d;

      // The output only follows the input after FILTER_LEN consecutive differing samples.
      always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (synced != filt_q) begin
          if (cnt_q == CntW'(FILTER_LEN - 1)) begin
            filt_d = synced;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_q  <= '0;
          filt_q <= 1'b1;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign line_o = filt_q;
    end
  endgenerate

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 receive stage: deframes 11-bit device-to-host frames, checks parity and stop,
// and presents the last two accepted bytes as a 16-bit scan-code history.
module ps2_frame_rx
  import ps2_frame_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        flag,
  output logic        frame_err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_f, data_s, fall;

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk_i (clk_50MHz),
    .rst_i (rst),
    .line_i(ps2_clk),
    .line_o(clk_f)
  );

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (0)
  ) u_data_sync (
    .clk_i (clk_50MHz),
    .rst_i (rst),
    .line_i(ps2_data),
    .line_o(data_s)
  );

  ps2_state_e      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [15:0]     keycode_q, keycode_d;
  logic            flag_q, flag_d;
  logic            frame_err_q, frame_err_d;
  logic            clk_f_q;

  assign fall = clk_f_q & ~clk_f;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    keycode_d   = keycode_q;
    flag_d      = 1'b0;
    frame_err_d = 1'b0;
    tmo_d       = (state_q == StIdle || fall) ? '0 : tmo_q + TmoW'(1);

    unique case (state_q)
      StIdle: begin
        if (fall && !data_s) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(FRAME_DATA_BITS - 1)) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (fall) begin
          parity_d = data_s;
          state_d  = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          if (data_s && odd_parity_ok(shift_q, parity_q)) begin
            keycode_d = {keycode_q[7:0], shift_q};
            flag_d    = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A stalled frame is dropped silently so the next start bit resynchronises.
    if (state_q != StIdle && !fall && tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
      state_d = StIdle;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      keycode_q   <= '0;
      flag_q      <= 1'b0;
      frame_err_q <= 1'b0;
      clk_f_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      keycode_q   <= keycode_d;
      flag_q      <= flag_d;
      frame_err_q <= frame_err_d;
      clk_f_q     <= clk_f;
    end
  end

  assign keycode   = keycode_q;
  assign flag      = flag_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx: directed scenarios followed by random frames.
module tb_ps2_frame_rx;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned FilterLen  = 8;
  localparam int unsigned TimeoutCyc = 300;
  localparam int          Latency    = SyncStages + FilterLen + 1;

  logic        clk_50MHz = 1'b0;
  logic        rst       = 1'b1;
  logic        ps2_clk   = 1'b1;
  logic        ps2_data  = 1'b1;
  logic [15:0] keycode;
  logic        flag;
  logic        frame_err;

  ps2_frame_rx #(
    .SYNC_STAGES   (SyncStages),
    .FILTER_LEN    (FilterLen),
    .TIMEOUT_CYCLES(TimeoutCyc)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .keycode  (keycode),
    .flag     (flag),
    .frame_err(frame_err)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  typedef struct {
    bit          is_flag;
    logic [15:0] kc;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_kc = 16'h0000;
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  always @(posedge clk_50MHz) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50MHz);
    #1;
  endtask

  // Sends the first nbits of a frame; the model predicts the response of a complete frame.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int half, input bit glitch, input int nbits);
    logic [10:0] bits;
    exp_t        e;
    bits = {~bad_stop, ~^b ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch) begin
        tick(12); ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(half - 15);
      end else begin
        tick(half);
      end
      ps2_clk = 1'b0;
      if (i == 10) begin
        e.is_flag = !bad_par && !bad_stop;
        if (e.is_flag) model_kc = {model_kc[7:0], b};
        e.kc  = model_kc;
        e.cyc = cyc + Latency;
        exp_q.push_back(e);
      end
      if (glitch) begin
        tick(12); ps2_clk = 1'b1; tick(3); ps2_clk = 1'b0; tick(half - 15);
      end else begin
        tick(half);
      end
      ps2_clk = 1'b1;
    end
    if (nbits == 11) ps2_data = 1'b1;
  endtask

  always @(negedge clk_50MHz) begin
    exp_t e;
    if (!rst && (flag || frame_err)) begin
      check(!(flag && frame_err), "flag_err_exclusive", {flag, frame_err}, 2'b00);
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_pulse", {flag, frame_err}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check(flag == e.is_flag, "pulse_kind_flag", flag, e.is_flag);
        check(keycode == e.kc, "keycode", keycode, e.kc);
        check(cyc == e.cyc, "pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    tick(5);
    rst = 1'b0;
    @(negedge clk_50MHz);
    check(keycode == 16'h0000, "reset_keycode", keycode, 16'h0000);
    check(flag == 1'b0, "reset_flag", flag, 1'b0);
    check(frame_err == 1'b0, "reset_frame_err", frame_err, 1'b0);
    tick(20);

    send_frame(8'h29, 1'b0, 1'b0, 20, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 1'b0, 20, 1'b0, 11);
    send_frame(8'h6B, 1'b0, 1'b0, 20, 1'b0, 11);
    tick(30);
    send_frame(8'h74, 1'b1, 1'b0, 22, 1'b0, 11);
    send_frame(8'h74, 1'b0, 1'b1, 22, 1'b0, 11);
    tick(30);

    // Short low pulse on the clock with data low must not look like a start bit.
    ps2_data = 1'b0;
    tick(2);
    ps2_clk = 1'b0; tick(5); ps2_clk = 1'b1;
    tick(30);
    ps2_data = 1'b1;
    tick(30);
    send_frame(8'h1C, 1'b0, 1'b0, 24, 1'b1, 11);
    tick(30);

    // Stalled frame, then a clean one.
    send_frame(8'h55, 1'b0, 1'b0, 20, 1'b0, 5);
    ps2_data = 1'b1;
    tick(2 * TimeoutCyc);
    send_frame(8'h29, 1'b0, 1'b0, 20, 1'b0, 11);
    tick(30);

    // Reset after the fifth data bit.
    send_frame(8'hA5, 1'b0, 1'b0, 20, 1'b0, 6);
    ps2_data = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_kc = 16'h0000;
    exp_q.delete();
    @(negedge clk_50MHz);
    check(keycode == 16'h0000, "midframe_reset_keycode", keycode, 16'h0000);
    check(flag == 1'b0, "midframe_reset_flag", flag, 1'b0);
    tick(40);
    send_frame(8'h6B, 1'b0, 1'b0, 20, 1'b0, 11);
    tick(30);

    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom);
      send_frame(b, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(20, 28), $urandom_range(0, 1) == 1, 11);
      tick($urandom_range(0, 30));
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    check(exp_q.size() == 0, "pending_expectations", exp_q.size(), 0);
    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_frame_rx.md
Name: ps2_frame_rx

Overview:
Upstream PS/2 receive stage for the keyboard decoder. Synchronises and glitch-filters the raw PS/2 clock and data lines, deframes 11-bit device-to-host frames, and checks odd parity and the stop bit. Maintains a two-byte scan-code history, so break sequences (F0 xx) arrive as one 16-bit word. Pulses a one-cycle valid flag per accepted byte; the keyboard decoder consumes `keycode`/`flag`.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each PS/2 input before filtering (min 2)
FILTER_LEN, 8, consecutive identical synced samples required before the filtered PS/2 clock changes
TIMEOUT_CYCLES, 50000, clk_50MHz cycles without a filtered falling edge mid-frame before abort (1 ms)

Ports:
clk_50MHz  input  1  system clock, 50 MHz; all logic on rising edge
rst  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock from pin, asynchronous, idles high
ps2_data  input  1  raw PS/2 data from pin, asynchronous, idles high
keycode  output  16  [15:8] previous accepted byte, [7:0] newest accepted byte
flag  output  1  one-cycle pulse: keycode updated with a new byte
frame_err  output  1  one-cycle pulse: frame rejected (parity or stop error)

Behaviour:
- Interface: one clock, clk_50MHz; reset rst is synchronous and active-high.
- Reset values:
  - keycode=16'h0000, flag=0, frame_err=0.
  - Synchroniser and filter registers=1; filtered clock=1.
  - Filter counter, bit counter and timeout counter=0; FSM=IDLE.
- Sync: ps2_clk and ps2_data each pass through a SYNC_STAGES flop chain.
- Clock filter:
  - Counter increments while the synced clock differs from the filtered clock; it clears when they are equal.
  - When the counter reaches FILTER_LEN-1 while still differing, the filtered clock takes the new value and the counter clears.
  - Pulses shorter than FILTER_LEN cycles are ignored.
- Falling edge: one-cycle strobe `fall` when the filtered clock goes 1->0. Synced data is sampled in the same cycle.
- FSM, advancing only on `fall`:
  - IDLE: if sampled data=0 (start bit) -> DATA, bit counter=0. If data=1 -> stay IDLE; no error is reported.
  - DATA: shift data into shift[7:0] LSB-first. After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: if data=1 and the XOR of shift[7:0] with the parity bit is 1 (odd parity), the frame is accepted; otherwise it is rejected. Either way -> IDLE.
- Accept, with registered outputs one cycle after the stop-bit `fall`:
  - keycode <= {keycode[7:0], shift[7:0]}; flag=1 for exactly one cycle.
- Reject: keycode unchanged; frame_err=1 for one cycle; flag stays 0.
- flag and frame_err are never both 1.
- Timeout:
  - In any state other than IDLE, the timeout counter increments each cycle and clears on `fall`.
  - When it reaches TIMEOUT_CYCLES-1 -> IDLE, partial byte discarded, no flag and no frame_err.
  - The counter is held at 0 in IDLE.
- Reset mid-frame: the next cycle is in the reset state and the partial frame is lost. The first frame after reset is decoded normally.
- Back-to-back frames need no idle gap beyond the stop bit. A start bit on the `fall` right after STOP is accepted in IDLE.
- Break sequence F0 1C yields two flag pulses: keycode=16'hxxF0 first (upper byte = previously accepted byte), then 16'hF01C.
- No backpressure: the consumer must sample on flag. Bytes are at least ~600 us apart, so none can be dropped.

Decomposition:
- Shared package: PS/2 frame constants:
  - FRAME_DATA_BITS=8
  - BREAK_CODE=8'hF0
  - EXT_CODE=8'hE0
  - FSM state encoding {IDLE, DATA, PARITY, STOP}
- The keyboard decoder imports BREAK_CODE from the package instead of using a literal.
- One sub-module: ps2_line_filter, the synchroniser plus glitch filter, instantiated for ps2_clk. ps2_data uses only the synchroniser part, with FILTER_LEN bypass parameter = 0.

Test Plan:
1. Reset, then frame for 8'h29 (bits 0,1,0,0,1,0,1,0,0, parity 0, stop 1), PS/2 clock period 80 us -> one flag pulse exactly 1 cycle after the stop-bit fall; keycode=16'h0029; frame_err=0 throughout.
2. Frames 8'hF0 then 8'h6B back-to-back -> flags with keycode=16'h29F0 then 16'hF06B (after scenario 1).
3. Frame 8'h74 with parity bit inverted -> frame_err pulse, no flag, keycode unchanged. Repeat with stop bit=0 -> same response.
4. 100 ns (5-cycle) low glitch on ps2_clk while idle, plus 3-cycle glitches between real edges mid-frame -> no extra bits shifted; frame 8'h1C decodes correctly to keycode[7:0]=8'h1C.
5. Start bit plus 4 data bits, then the clock held high for 1.2 ms -> FSM returns to IDLE, no flag and no frame_err. A following full frame 8'h29 is accepted normally.
6. Assert rst for one cycle after the 5th data bit of a frame -> keycode=0 and flag=0 the next cycle, remaining bits ignored while the line is high. A subsequent frame 8'h6B gives keycode=16'h006B.
